// File: rtl/wb_data_ram.sv
// wb_data_ram: word-addressed Wishbone data RAM with programmable wait states.
//
// A request is accepted in IDLE when wb_cyc & wb_stb are high. The address,
// direction and write data are captured at that point. The FSM then waits
// WAIT_CYCLES cycles and raises wb_ack for exactly one cycle. Writes commit on
// the edge that ends the ACK cycle. Reads present data only during the ACK cycle.
//
// Ports:
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset (memory array is not cleared)
//   wb_cyc    bus cycle valid; dropping it in WAIT aborts the transfer
//   wb_stb    strobe; only qualified by wb_cyc
//   wb_we     1 = write, 0 = read
//   wb_adr    word address; any bit at or above ADDR_BITS makes it out of range
//   wb_dat_i  write data
//   wb_dat_o  registered read data, zero outside the ACK cycle
//   wb_ack    registered one-cycle transfer acknowledge
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no transfer in flight; accepts cyc&stb and latches request
// S_WAIT | counting down wait states; cyc low aborts back to IDLE
// S_ACK  | wb_ack high; write commits on the closing edge
module wb_data_ram #(
  parameter int DATA_W      = 32,
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [DATA_W-1:0] wb_adr,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [DATA_W-1:0] lat_adr, lat_dat;
  logic              lat_we;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic [DATA_W-1:0] acc_adr;
  logic              acc_we;
  logic              acc_in_range;
  logic              lat_in_range;
  logic              ack_nxt;
  logic [DATA_W-1:0] dat_nxt;

  assign accept = (state == S_IDLE) && wb_cyc && wb_stb;

  // With zero wait states the transfer enters ACK on the accept edge, so the
  // read data must come from the live bus rather than the latch.
  assign acc_adr      = accept ? wb_adr : lat_adr;
  assign acc_we       = accept ? wb_we  : lat_we;
  assign acc_in_range = (acc_adr >> ADDR_BITS) == '0;
  assign lat_in_range = (lat_adr >> ADDR_BITS) == '0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_ACK;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_nxt = S_ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_ACK: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    ack_nxt = (state_nxt == S_ACK);
    dat_nxt = '0;
    if (ack_nxt && !acc_we && acc_in_range) begin
      dat_nxt = mem[acc_adr[ADDR_BITS-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      lat_adr  <= '0;
      lat_dat  <= '0;
      lat_we   <= 1'b0;
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wb_ack   <= ack_nxt;
      wb_dat_o <= dat_nxt;
      if (accept) begin
        lat_adr <= wb_adr;
        lat_dat <= wb_dat_i;
        lat_we  <= wb_we;
      end
    end
  end

  // Reset forces state to IDLE asynchronously, so an interrupted ACK never
  // reaches this commit.
  always_ff @(posedge clk) begin
    if (state == S_ACK && lat_we && lat_in_range) begin
      mem[lat_adr[ADDR_BITS-1:0]] <= lat_dat;
    end
  end

endmodule

// File: tb/tb_wb_data_ram.sv
// Bench for wb_data_ram: four instances with WAIT_CYCLES = 0..3 (instance k
// has k wait states), a transaction-level reference model per instance, a
// per-cycle compare process and directed scenarios followed by random traffic.
module tb_wb_data_ram;
  localparam int DW = 32;
  localparam int AB = 10;
  localparam int NI = 4;
  localparam logic [31:0] DEPTH = 32'd1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic          cyc_s [NI];
  logic          stb_s [NI];
  logic          we_s  [NI];
  logic [DW-1:0] adr_s [NI];
  logic [DW-1:0] dat_s [NI];
  logic [NI-1:0] ack_s;
  logic [DW-1:0] dout_s [NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wb_data_ram #(.DATA_W(DW), .ADDR_BITS(AB), .WAIT_CYCLES(g)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wb_cyc  (cyc_s[g]),
      .wb_stb  (stb_s[g]),
      .wb_we   (we_s[g]),
      .wb_adr  (adr_s[g]),
      .wb_dat_i(dat_s[g]),
      .wb_dat_o(dout_s[g]),
      .wb_ack  (ack_s[g])
    );
  end

  // Reference model: one transfer record per instance plus a word array.
  bit          m_ack  [NI];
  bit          m_busy [NI];
  bit          m_we   [NI];
  int          m_rem  [NI];
  logic [31:0] m_adr  [NI];
  logic [31:0] m_dat  [NI];
  logic [31:0] mm     [NI][1024];
  bit          kn     [NI][1024];

  function automatic bit in_rng(logic [31:0] a);
    return a < DEPTH;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d got=%h exp=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_ack[k]  = 1'b0;
        m_busy[k] = 1'b0;
      end else if (m_ack[k]) begin
        if (m_we[k] && in_rng(m_adr[k])) begin
          mm[k][m_adr[k][9:0]] = m_dat[k];
          kn[k][m_adr[k][9:0]] = 1'b1;
        end
        m_ack[k]  = 1'b0;
        m_busy[k] = 1'b0;
      end else if (m_busy[k]) begin
        if (!cyc_s[k]) begin
          m_busy[k] = 1'b0;
        end else begin
          m_rem[k] = m_rem[k] - 1;
          if (m_rem[k] == 0) m_ack[k] = 1'b1;
        end
      end else if (cyc_s[k] && stb_s[k]) begin
        m_adr[k]  = adr_s[k];
        m_dat[k]  = dat_s[k];
        m_we[k]   = we_s[k];
        m_busy[k] = 1'b1;
        m_rem[k]  = k;
        if (k == 0) m_ack[k] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      chk("ack", k, {31'b0, ack_s[k]}, {31'b0, m_ack[k]});
      if (m_ack[k] && !m_we[k] && in_rng(m_adr[k])) begin
        if (kn[k][m_adr[k][9:0]]) chk("rdata", k, dout_s[k], mm[k][m_adr[k][9:0]]);
      end else begin
        chk("dat_zero", k, dout_s[k], 32'h0);
      end
    end
  end

  // Caller is aligned 1 time unit after a rising edge. Returns the number of
  // edges from (and including) the accept edge to ack, or -1 on timeout.
  task automatic xfer(input int k, input bit we, input logic [31:0] adr,
                      input logic [31:0] dat, input bit scramble,
                      output logic [31:0] rd, output int lat);
    bit done;
    done = 1'b0;
    lat = 0;
    rd = '0;
    cyc_s[k] = 1'b1; stb_s[k] = 1'b1; we_s[k] = we; adr_s[k] = adr; dat_s[k] = dat;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack_s[k]) begin
        rd = dout_s[k];
        done = 1'b1;
      end else if (scramble) begin
        adr_s[k] = $urandom;
        dat_s[k] = $urandom;
        we_s[k]  = 1'($urandom_range(0, 1));
      end
    end
    cyc_s[k] = 1'b0; stb_s[k] = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL xfer_timeout inst=%0d adr=%h", k, adr);
      lat = -1;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_adr();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 16) return 32'($urandom_range(0, 15));
    if (r == 16) return 32'd1023;
    if (r == 17) return 32'd1024;
    return $urandom | 32'h400;
  endfunction

  logic [31:0] rd;
  int lat;
  bit seq_ack [5];
  logic [31:0] seq_dat [5];

  initial begin
    for (int k = 0; k < NI; k++) begin
      cyc_s[k] = 1'b0; stb_s[k] = 1'b0; we_s[k] = 1'b0; adr_s[k] = '0; dat_s[k] = '0;
    end
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_ack", k, {31'b0, ack_s[k]}, 32'h0);
      chk("rst_dat", k, dout_s[k], 32'h0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // One wait state: write then read back address 5.
    xfer(1, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, rd, lat);
    chk("w1_wr_lat", 1, 32'(lat), 32'd2);
    chk("model_pin5", 1, mm[1][5], 32'hDEADBEEF);
    xfer(1, 1'b0, 32'd5, 32'h0, 1'b0, rd, lat);
    chk("w1_rd_lat", 1, 32'(lat), 32'd2);
    chk("w1_rd_data", 1, rd, 32'hDEADBEEF);

    // Out-of-range write must not alias onto word 0; top in-range word works.
    xfer(1, 1'b1, 32'd0, 32'h0BAD0000, 1'b0, rd, lat);
    xfer(1, 1'b1, 32'h400, 32'h1234, 1'b0, rd, lat);
    chk("oor_wr_acked", 1, 32'(lat), 32'd2);
    xfer(1, 1'b0, 32'd0, 32'h0, 1'b0, rd, lat);
    chk("oor_word0", 1, rd, 32'h0BAD0000);
    xfer(1, 1'b0, 32'h400, 32'h0, 1'b0, rd, lat);
    chk("oor_rd_zero", 1, rd, 32'h0);
    xfer(1, 1'b1, 32'd1023, 32'h5A5A0FF0, 1'b0, rd, lat);
    xfer(1, 1'b0, 32'd1023, 32'h0, 1'b0, rd, lat);
    chk("top_word", 1, rd, 32'h5A5A0FF0);

    // Zero wait states, cyc/stb held: ack, idle, ack, idle, ack.
    for (int a = 1; a <= 3; a++) begin
      xfer(0, 1'b1, 32'(a), 32'h1111_0000 + 32'(a), 1'b0, rd, lat);
      chk("w0_wr_lat", 0, 32'(lat), 32'd1);
    end
    cyc_s[0] = 1'b1; stb_s[0] = 1'b1; we_s[0] = 1'b0; adr_s[0] = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      seq_ack[i] = ack_s[0];
      seq_dat[i] = dout_s[0];
      if (ack_s[0]) adr_s[0] = adr_s[0] + 32'd1;
    end
    cyc_s[0] = 1'b0; stb_s[0] = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("b2b_ack", i, {31'b0, seq_ack[i]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("b2b_dat", i, seq_dat[i], (i % 2 == 0) ? 32'h1111_0001 + 32'(i / 2) : 32'h0);
    end

    // Three wait states: abort a write by dropping cyc after accept.
    xfer(3, 1'b1, 32'd7, 32'h5555, 1'b0, rd, lat);
    chk("w3_wr_lat", 3, 32'(lat), 32'd4);
    cyc_s[3] = 1'b1; stb_s[3] = 1'b1; we_s[3] = 1'b1; adr_s[3] = 32'd7; dat_s[3] = 32'hAAAA;
    @(posedge clk); #1;
    cyc_s[3] = 1'b0; stb_s[3] = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_noack", 3, {31'b0, ack_s[3]}, 32'h0);
    end
    xfer(3, 1'b0, 32'd7, 32'h0, 1'b0, rd, lat);
    chk("abort_old", 3, rd, 32'h5555);
    chk("w3_rd_lat", 3, 32'(lat), 32'd4);

    // Two wait states: bus changes during WAIT do not affect the transfer.
    xfer(2, 1'b1, 32'h20, 32'hCAFEF00D, 1'b1, rd, lat);
    chk("w2_lat", 2, 32'(lat), 32'd3);
    xfer(2, 1'b0, 32'h20, 32'h0, 1'b0, rd, lat);
    chk("scramble_data", 2, rd, 32'hCAFEF00D);

    // Reset during WAIT of a write.
    xfer(3, 1'b1, 32'd9, 32'h9999, 1'b0, rd, lat);
    cyc_s[3] = 1'b1; stb_s[3] = 1'b1; we_s[3] = 1'b1; adr_s[3] = 32'd9; dat_s[3] = 32'h7777;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_ack", 3, {31'b0, ack_s[3]}, 32'h0);
    cyc_s[3] = 1'b0; stb_s[3] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(3, 1'b0, 32'd9, 32'h0, 1'b0, rd, lat);
    chk("rst_wait_old", 3, rd, 32'h9999);
    chk("rst_wait_lat", 3, 32'(lat), 32'd4);

    // Reset during the ACK cycle of a write drops the ack and the commit.
    xfer(1, 1'b1, 32'd9, 32'h1919, 1'b0, rd, lat);
    cyc_s[1] = 1'b1; stb_s[1] = 1'b1; we_s[1] = 1'b1; adr_s[1] = 32'd9; dat_s[1] = 32'h2828;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ack_before_rst", 1, {31'b0, ack_s[1]}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack_drop", 1, {31'b0, ack_s[1]}, 32'h0);
    chk("rst_dat_drop", 1, dout_s[1], 32'h0);
    cyc_s[1] = 1'b0; stb_s[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(1, 1'b0, 32'd9, 32'h0, 1'b0, rd, lat);
    chk("rst_ack_old", 1, rd, 32'h1919);

    // Random traffic on all instances, checked by the compare process.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      for (int k = 0; k < NI; k++) begin
        cyc_s[k] = ($urandom_range(0, 9) < 8);
        stb_s[k] = ($urandom_range(0, 9) < 7);
        we_s[k]  = 1'($urandom_range(0, 1));
        adr_s[k] = pick_adr();
        dat_s[k] = $urandom;
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) begin
      cyc_s[k] = 1'b0; stb_s[k] = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
